clz_part_select: RTL and testbench
==================================

Name: clz_part_select

Overview:
- Registered bit-field analysis unit for quire-to-posit normalisation.
- Each accepted input word produces three results together:
  - a leading-zero count with a constant offset,
  - a fixed-position part select with negative-index protection,
  - an OR-reduction over a fixed index range.
- Used upstream of exponent/fraction formation, where the leading one and the guard/sticky bits must be located.

Parameters:
- WIDTH, 16, input word width (>=1).
- ADD_OFFSET, 0, constant added to the leading-zero count (0 or 1; 1 skips the leading one).
- SEL_START, 7, signed MSB index of the part select; may be negative or >= WIDTH.
- SEL_WIDTH, 2, part-select output width (>=1).
- OR_START, 4, signed MSB index of the OR-reduce range.
- OR_END, 0, signed LSB index of the OR-reduce range.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid this cycle
- in_data  in  WIDTH  word to analyse
- out_valid  out  1  results valid
- clz_out  out  $clog2(WIDTH+2)  leading-zero count plus ADD_OFFSET
- sel_out  out  SEL_WIDTH  selected field
- or_out  out  1  OR of the selected range

Behaviour:
- One clock domain. Reset is asynchronous on resetn low; release is synchronous to clock.
- Reset values: out_valid=0, clz_out=0, sel_out=0, or_out=0.
- Latency is 1 cycle.
  - On a clock edge with in_valid=1: all three results are computed from in_data and registered, and out_valid is set to 1.
  - On an edge with in_valid=0: out_valid becomes 0 and the result registers hold their last values.
- No backpressure; a new word is accepted every cycle.
- clz_out:
  - Let k = number of consecutive zeros starting at in_data[WIDTH-1].
  - clz_out = k + ADD_OFFSET.
  - All-zero input: clz_out = WIDTH + ADD_OFFSET; the width is sized so this never wraps.
  - Any priority/tree structure is acceptable if the result matches.
- sel_out:
  - sel_out[SEL_WIDTH-1-i] = in_data[SEL_START-i] for i = 0..SEL_WIDTH-1.
  - Any source index < 0 or >= WIDTH reads as 0.
  - The select must elaborate legally for negative SEL_START (entire output 0).
- or_out:
  - OR of in_data[j] for OR_END <= j <= OR_START, with the range clipped to [0, WIDTH-1].
  - Empty range (OR_START < OR_END, or OR_START < 0, or OR_END >= WIDTH): or_out = 0.
- Parameter legality is checked at elaboration: WIDTH>=1, SEL_WIDTH>=1, ADD_OFFSET in {0,1}.
- Reset asserted mid-stream: outputs go to reset values immediately; the word in flight is discarded.

Decomposition:
- Shared package: function clzBits(width) = $clog2(width+2), and a clipped-range helper (lo/hi clamp to [0, WIDTH-1], empty flag).
- One natural combinational sub-module: count_leading_zeros_core (WIDTH, ADD_OFFSET).
- Part select and OR-reduce are generate loops in the top.
- The top owns the output registers.

Test Plan:
- Reset: hold resetn=0 with in_valid=1 -> out_valid=0, clz_out=0, sel_out=0, or_out=0; release -> first valid result appears 1 cycle after the first sampled in_valid.
- CLZ sweep, WIDTH=16, ADD_OFFSET=1:
  - 0x8000 -> 1; 0x4000 -> 2; 0x0001 -> 16; 0x0000 -> 17 (5-bit output, no wrap).
  - With ADD_OFFSET=0: 0x00F0 -> 8.
- Part select, SEL_START=7, SEL_WIDTH=2:
  - 0x00C0 -> sel_out=2'b11; 0x0080 -> 2'b10.
  - SEL_START=0: 0x0001 -> 2'b10 (low bit padded 0).
  - SEL_START=-1 -> 2'b00 for all inputs.
- OR-reduce, OR_START=4, OR_END=0:
  - 0x0010 -> 1; 0x0020 -> 0.
  - OR_START=14, OR_END=5: 0x4000 -> 1.
  - OR_START=-3 -> 0 for all inputs.
- Streaming: back-to-back in_valid with 0x8000, 0x0000, 0x0100 -> three consecutive out_valid cycles, clz_out 1, 17, 8 (ADD_OFFSET=1); an in_valid=0 gap drops out_valid and holds the values.
- Random: 1000 random words per parameter set, each compared against a software model of all three outputs.

Source files
------------

// File: rtl/clz_part_select_pkg.sv
// Shared types and elaboration-time helpers for the bit-field analysis unit.
package clz_part_select_pkg;

    // Clipped index range: lo/hi clamped into the word, empty when nothing is left.
    typedef struct packed {
        int   lo;
        int   hi;
        logic empty;
    } rangeT;

    // Width of a leading-zero count that must also hold WIDTH+1 without wrapping.
    function automatic int clzBits(input int width);
        return $clog2(width + 2);
    endfunction

    // Clamp [loIdx, hiIdx] into [0, width-1]; flag ranges with no bit inside the word.
    function automatic rangeT clipRange(input int hiIdx, input int loIdx, input int width);
        rangeT r;
        r.lo    = (loIdx < 0) ? 0 : loIdx;
        r.hi    = (hiIdx > width - 1) ? width - 1 : hiIdx;
        r.empty = (hiIdx < loIdx) || (hiIdx < 0) || (loIdx >= width);
        return r;
    endfunction

endpackage

// File: rtl/clz_part_select_clz.sv
// Combinational leading-zero counter with a constant offset added to the count.
module count_leading_zeros_core
    import clz_part_select_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADD_OFFSET = 0
) (
    input  logic [WIDTH-1:0]          inData,
    output logic [clzBits(WIDTH)-1:0] clzCount
);

    localparam int CW = clzBits(WIDTH);

    // Scan upward so the highest set bit is the last one to overwrite the count.
    always_comb begin
        clzCount = CW'(WIDTH + ADD_OFFSET);
        for (int i = 0; i < WIDTH; i++) begin
            if (inData[i]) begin
                clzCount = CW'(WIDTH - 1 - i + ADD_OFFSET);
            end
        end
    end

endmodule

// File: rtl/clz_part_select.sv
// Registered leading-zero count, guarded part select and range OR-reduce.
module clz_part_select
    import clz_part_select_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADD_OFFSET = 0,
    parameter int SEL_START  = 7,
    parameter int SEL_WIDTH  = 2,
    parameter int OR_START   = 4,
    parameter int OR_END     = 0
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    output logic [clzBits(WIDTH)-1:0] clz_out,
    output logic [SEL_WIDTH-1:0]      sel_out,
    output logic                      or_out
);

    localparam int    CW       = clzBits(WIDTH);
    localparam rangeT OR_RANGE = clipRange(OR_START, OR_END, WIDTH);
    localparam int    OR_LO    = OR_RANGE.lo;
    localparam int    OR_HI    = OR_RANGE.hi;

    if (WIDTH < 1) begin : gBadWidth
        $error("clz_part_select: WIDTH must be >= 1");
    end
    if (SEL_WIDTH < 1) begin : gBadSelWidth
        $error("clz_part_select: SEL_WIDTH must be >= 1");
    end
    if (ADD_OFFSET != 0 && ADD_OFFSET != 1) begin : gBadOffset
        $error("clz_part_select: ADD_OFFSET must be 0 or 1");
    end

    logic [CW-1:0]        clzNext;
    logic [SEL_WIDTH-1:0] selNext;
    logic                 orNext;

    count_leading_zeros_core #(
        .WIDTH      (WIDTH),
        .ADD_OFFSET (ADD_OFFSET)
    ) uClz (
        .inData   (in_data),
        .clzCount (clzNext)
    );

    // Each select bit taps its source index, or ties to 0 when that index is outside the word.
    for (genvar i = 0; i < SEL_WIDTH; i++) begin : gSel
        localparam int SRC = SEL_START - i;
        if (SRC >= 0 && SRC < WIDTH) begin : gTap
            assign selNext[SEL_WIDTH-1-i] = in_data[SRC];
        end else begin : gPad
            assign selNext[SEL_WIDTH-1-i] = 1'b0;
        end
    end

    // OR over the clipped range; masked-off bits contribute 0, an empty range yields 0.
    if (OR_RANGE.empty) begin : gOrEmpty
        assign orNext = 1'b0;
    end else begin : gOrRange
        logic [WIDTH-1:0] orTaps;
        for (genvar j = 0; j < WIDTH; j++) begin : gOrBit
            if (j >= OR_LO && j <= OR_HI) begin : gIn
                assign orTaps[j] = in_data[j];
            end else begin : gOut
                assign orTaps[j] = 1'b0;
            end
        end
        assign orNext = |orTaps;
    end

    // Capture all three results together on an accepted word; hold them otherwise.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            clz_out   <= '0;
            sel_out   <= '0;
            or_out    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                clz_out <= clzNext;
                sel_out <= selNext;
                or_out  <= orNext;
            end
        end
    end

endmodule

// File: tb/tb_clz_part_select.sv
// Self-checking bench: four parameter sets share one stimulus stream and one reference model.
module tb_clz_part_select;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic [15:0] in_data;

    // Parameter sets: A default-ish, B low select / high OR, C negative indices, D narrow with clipping.
    localparam int P_W  [4] = '{16, 16, 16, 5};
    localparam int P_OFF[4] = '{1, 0, 0, 1};
    localparam int P_SS [4] = '{7, 0, -1, 6};
    localparam int P_SW [4] = '{2, 2, 2, 3};
    localparam int P_OS [4] = '{4, 14, -3, 20};
    localparam int P_OE [4] = '{0, 5, 0, 2};

    logic       vA, vB, vC, vD;
    logic [4:0] clzA, clzB, clzC;
    logic [2:0] clzD;
    logic [1:0] selA, selB, selC;
    logic [2:0] selD;
    logic       orA, orB, orC, orD;

    clz_part_select #(.WIDTH(16), .ADD_OFFSET(1), .SEL_START(7), .SEL_WIDTH(2), .OR_START(4), .OR_END(0)) dutA (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .out_valid(vA), .clz_out(clzA), .sel_out(selA), .or_out(orA));
    clz_part_select #(.WIDTH(16), .ADD_OFFSET(0), .SEL_START(0), .SEL_WIDTH(2), .OR_START(14), .OR_END(5)) dutB (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .out_valid(vB), .clz_out(clzB), .sel_out(selB), .or_out(orB));
    clz_part_select #(.WIDTH(16), .ADD_OFFSET(0), .SEL_START(-1), .SEL_WIDTH(2), .OR_START(-3), .OR_END(0)) dutC (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .out_valid(vC), .clz_out(clzC), .sel_out(selC), .or_out(orC));
    clz_part_select #(.WIDTH(5), .ADD_OFFSET(1), .SEL_START(6), .SEL_WIDTH(3), .OR_START(20), .OR_END(2)) dutD (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_data(in_data[4:0]),
        .out_valid(vD), .clz_out(clzD), .sel_out(selD), .or_out(orD));

    logic        obsValid[4];
    logic [31:0] obsClz[4];
    logic [31:0] obsSel[4];
    logic [31:0] obsOr[4];

    always_comb begin
        obsValid[0] = vA; obsValid[1] = vB; obsValid[2] = vC; obsValid[3] = vD;
        obsClz[0] = 32'(clzA); obsClz[1] = 32'(clzB); obsClz[2] = 32'(clzC); obsClz[3] = 32'(clzD);
        obsSel[0] = 32'(selA); obsSel[1] = 32'(selB); obsSel[2] = 32'(selC); obsSel[3] = 32'(selD);
        obsOr[0] = 32'(orA); obsOr[1] = 32'(orB); obsOr[2] = 32'(orC); obsOr[3] = 32'(orD);
    end

    logic        expValid;
    logic [31:0] expClz[4];
    logic [31:0] expSel[4];
    logic [31:0] expOr[4];

    int errors = 0;
    int checks = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model straight from the bit-field rules.
    function automatic void model(input int k, input logic [15:0] d,
                                  output logic [31:0] c, output logic [31:0] s, output logic [31:0] o);
        int w = P_W[k];
        int n = 0;
        while (n < w && d[w-1-n] == 1'b0) n++;
        c = 32'(n + P_OFF[k]);
        s = 0;
        for (int i = 0; i < P_SW[k]; i++) begin
            int idx = P_SS[k] - i;
            s = s << 1;
            if (idx >= 0 && idx < w && d[idx]) s = s | 32'd1;
        end
        o = 0;
        for (int j = P_OE[k]; j <= P_OS[k]; j++) begin
            if (j >= 0 && j < w && d[j]) o = 1;
        end
    endfunction

    function automatic void clearExpected();
        expValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expClz[k] = 0; expSel[k] = 0; expOr[k] = 0;
        end
    endfunction

    // Drive one cycle of stimulus and advance the model's registered view; leaves time at edge+1.
    task automatic step(input logic v, input logic [15:0] d);
        logic [31:0] c, s, o;
        @(negedge clock);
        in_valid = v;
        in_data  = d;
        @(posedge clock);
        expValid = v;
        if (v) begin
            for (int k = 0; k < 4; k++) begin
                model(k, d, c, s, o);
                expClz[k] = c; expSel[k] = s; expOr[k] = o;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obsValid[k] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %0b want 0", k, obsValid[k]); end
            checks++;
            if (obsClz[k] !== 0) begin errors++; $display("FAIL reset_clz[%0d]: got %0d want 0", k, obsClz[k]); end
            checks++;
            if (obsSel[k] !== 0) begin errors++; $display("FAIL reset_sel[%0d]: got %0d want 0", k, obsSel[k]); end
            checks++;
            if (obsOr[k] !== 0) begin errors++; $display("FAIL reset_or[%0d]: got %0d want 0", k, obsOr[k]); end
        end
        @(negedge clock);
        resetn = 1'b1;
        clearExpected();
        #1;
        checks++;
        if (vA !== 1'b0) begin errors++; $display("FAIL release_valid_early: got %0b want 0", vA); end
        step(1'b1, 16'hFFFF);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obsValid[k] !== expValid) begin errors++; $display("FAIL first_valid[%0d]: got %0b want %0b", k, obsValid[k], expValid); end
            checks++;
            if (obsClz[k] !== expClz[k]) begin errors++; $display("FAIL first_clz[%0d]: got %0d want %0d", k, obsClz[k], expClz[k]); end
        end
    endtask

    typedef struct {
        logic [15:0] word;
        int          inst;
        int          field;  // 0 clz, 1 sel, 2 or
        int          want;
    } planT;

    // Hand-derived values for specific words, independent of the reference model.
    task automatic test_plan_values();
        planT plan[$] = '{
            '{16'h8000, 0, 0, 1},  '{16'h4000, 0, 0, 2},  '{16'h0001, 0, 0, 16},
            '{16'h0000, 0, 0, 17}, '{16'h00F0, 1, 0, 8},  '{16'h00C0, 0, 1, 3},
            '{16'h0080, 0, 1, 2},  '{16'h0001, 1, 1, 2},  '{16'hFFFF, 2, 1, 0},
            '{16'h0010, 0, 2, 1},  '{16'h0020, 0, 2, 0},  '{16'h4000, 1, 2, 1},
            '{16'hFFFF, 2, 2, 0},  '{16'h0000, 3, 0, 6},  '{16'h0010, 3, 1, 1},
            '{16'h0004, 3, 2, 1},  '{16'h0003, 3, 2, 0}
        };
        foreach (plan[p]) begin
            logic [31:0] got;
            step(1'b1, plan[p].word);
            got = (plan[p].field == 0) ? obsClz[plan[p].inst] :
                  (plan[p].field == 1) ? obsSel[plan[p].inst] : obsOr[plan[p].inst];
            checks++;
            if (got !== 32'(plan[p].want)) begin
                errors++;
                $display("FAIL plan[%0d] inst=%0d field=%0d word=%h: got %0d want %0d",
                         p, plan[p].inst, plan[p].field, plan[p].word, got, plan[p].want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words[3] = '{16'h8000, 16'h0000, 16'h0100};
        int          wantA[3] = '{1, 17, 8};
        foreach (words[w]) begin
            step(1'b1, words[w]);
            checks++;
            if (vA !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b want 1", w, vA); end
            checks++;
            if (32'(clzA) !== 32'(wantA[w])) begin errors++; $display("FAIL b2b_clz[%0d]: got %0d want %0d", w, clzA, wantA[w]); end
        end
        step(1'b0, 16'h8000);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obsValid[k] !== 1'b0) begin errors++; $display("FAIL gap_valid[%0d]: got %0b want 0", k, obsValid[k]); end
            checks++;
            if (obsClz[k] !== expClz[k]) begin errors++; $display("FAIL gap_clz_hold[%0d]: got %0d want %0d", k, obsClz[k], expClz[k]); end
            checks++;
            if (obsSel[k] !== expSel[k]) begin errors++; $display("FAIL gap_sel_hold[%0d]: got %0d want %0d", k, obsSel[k], expSel[k]); end
            checks++;
            if (obsOr[k] !== expOr[k]) begin errors++; $display("FAIL gap_or_hold[%0d]: got %0d want %0d", k, obsOr[k], expOr[k]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1000; n++) begin
            logic        v;
            logic [15:0] d;
            v = ($urandom_range(0, 9) < 8);
            // Bias toward short words so high leading-zero counts show up often.
            d = 16'($urandom) >> $urandom_range(0, 16);
            step(v, d);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obsValid[k] !== expValid) begin errors++; $display("FAIL rand_valid[%0d] n=%0d: got %0b want %0b", k, n, obsValid[k], expValid); end
                checks++;
                if (obsClz[k] !== expClz[k]) begin errors++; $display("FAIL rand_clz[%0d] n=%0d d=%h: got %0d want %0d", k, n, d, obsClz[k], expClz[k]); end
                checks++;
                if (obsSel[k] !== expSel[k]) begin errors++; $display("FAIL rand_sel[%0d] n=%0d d=%h: got %0d want %0d", k, n, d, obsSel[k], expSel[k]); end
                checks++;
                if (obsOr[k] !== expOr[k]) begin errors++; $display("FAIL rand_or[%0d] n=%0d d=%h: got %0d want %0d", k, n, d, obsOr[k], expOr[k]); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 16'h0F0F);
        @(negedge clock);
        in_data = 16'h8000;
        #2;
        resetn = 1'b0;
        clearExpected();
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obsValid[k] !== 1'b0) begin errors++; $display("FAIL midreset_valid[%0d]: got %0b want 0", k, obsValid[k]); end
            checks++;
            if (obsClz[k] !== 0) begin errors++; $display("FAIL midreset_clz[%0d]: got %0d want 0", k, obsClz[k]); end
            checks++;
            if (obsSel[k] !== 0 || obsOr[k] !== 0) begin
                errors++; $display("FAIL midreset_sel_or[%0d]: got %0d/%0d want 0/0", k, obsSel[k], obsOr[k]);
            end
        end
        @(posedge clock);
        #1;
        checks++;
        if (vA !== 1'b0) begin errors++; $display("FAIL midreset_discard: got valid %0b want 0", vA); end
        @(negedge clock);
        resetn = 1'b1;
        step(1'b1, 16'h0100);
        checks++;
        if (vA !== 1'b1 || clzA !== 5'd8) begin errors++; $display("FAIL post_reset: got valid %0b clz %0d want 1/8", vA, clzA); end
    endtask

    initial begin
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clearExpected();
        test_reset();
        test_plan_values();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
